array_controller: RTL and testbench

ARRAY_CONTROLLER -- requirements
Module: array_controller

---
 rtl/ctrl_pkg.sv | 49 ++++
 rtl/beat_counter.sv | 25 ++
 rtl/array_controller.sv | 161 ++++++++++++++++
 tb/tb_array_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the systolic array controller: instruction field
// positions, opcode values, FSM state type and opcode decode helpers.
package ctrl_pkg;

  localparam int OPC_HI  = 63;
  localparam int OPC_LO  = 60;
  localparam int BASE_HI = 59;
  localparam int BASE_LO = 44;
  localparam int LEN_HI  = 43;
  localparam int LEN_LO  = 32;

  localparam int OPC_W  = 4;
  localparam int BASE_W = 16;
  localparam int LEN_W  = 12;
  localparam int CNT_W  = 16;

  localparam logic [OPC_W-1:0] OP_NOP     = 4'd0;
  localparam logic [OPC_W-1:0] OP_LOAD_W  = 4'd1;
  localparam logic [OPC_W-1:0] OP_LOAD_A  = 4'd2;
  localparam logic [OPC_W-1:0] OP_COMPUTE = 4'd3;
  localparam logic [OPC_W-1:0] OP_STORE   = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  // Opcodes above STORE are reserved and treated as illegal.
  function automatic logic op_legal(input logic [OPC_W-1:0] op);
    return op <= OP_STORE;
  endfunction

  // Strobe vector ordered {store, compute, act_load, wt_load}.
  function automatic logic [3:0] op_strobe(input logic [OPC_W-1:0] op);
    logic [3:0] s;
    s = 4'b0000;
    case (op)
      OP_LOAD_W:  s = 4'b0001;
      OP_LOAD_A:  s = 4'b0010;
      OP_COMPUTE: s = 4'b0100;
      OP_STORE:   s = 4'b1000;
      default:    s = 4'b0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Loadable down-counter holding the number of remaining beats in the
// current RUN or DRAIN phase. Stops at zero; load wins over decrement.
module beat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  // Load, or count down toward zero while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/array_controller.sv
// Instruction sequencer for a systolic array. Accepts one 64-bit instruction
// at a time in IDLE, streams LEN strobe beats with incrementing addresses,
// drains the array after COMPUTE, then pulses done (and err for illegal
// opcodes). Optional build macro CTRL_PERF_CNT_EN adds a saturating
// busy-cycle counter output perf_busy_cycles.
module array_controller import ctrl_pkg::*; #(
  parameter int ARRAY_N = 4,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       instr_in,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              wt_load_en,
  output logic              act_load_en,
  output logic              compute_en,
  output logic              store_en,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       perf_busy_cycles
`endif
);

  // Drain takes 2*ARRAY_N-1 cycles; the counter runs from this value to 0.
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2 * ARRAY_N - 2);

  state_t             state;
  logic [OPC_W-1:0]   op_q;
  logic [3:0]         strb_q;
  logic [OPC_W-1:0]   op_in;
  logic [BASE_W-1:0]  base_in;
  logic [LEN_W-1:0]   len_in;
  logic               accept;
  logic               start_run;
  logic               cnt_load;
  logic               cnt_dec;
  logic [CNT_W-1:0]   cnt_load_val;
  logic [CNT_W-1:0]   cnt;
  logic               last_beat;
  logic               unused_rsvd;

  assign op_in       = instr_in[OPC_HI:OPC_LO];
  assign base_in     = instr_in[BASE_HI:BASE_LO];
  assign len_in      = instr_in[LEN_HI:LEN_LO];
  assign unused_rsvd = ^instr_in[31:0];

  assign instr_ready = (state == S_IDLE);
  assign accept      = instr_ready && instr_valid;
  assign start_run   = op_legal(op_in) && (op_in != OP_NOP) && (len_in != '0);
  assign last_beat   = (cnt == '0);

  assign {store_en, compute_en, act_load_en, wt_load_en} = strb_q;

  // Counter loads LEN-1 at acceptance and the drain length after the last COMPUTE beat.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = (state == S_RUN) || (state == S_DRAIN);
    if (accept && start_run) begin
      cnt_load     = 1'b1;
      cnt_load_val = CNT_W'(len_in) - CNT_W'(1);
    end else if ((state == S_RUN) && last_beat && (op_q == OP_COMPUTE)) begin
      cnt_load     = 1'b1;
      cnt_load_val = DRAIN_LAST;
    end
  end

  beat_counter #(
    .CNT_W (CNT_W)
  ) u_beat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt)
  );

  // Main sequencer with registered strobes, address, busy, done and err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_NOP;
      strb_q <= 4'b0000;
      addr   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (accept) begin
            op_q <= op_in;
            busy <= 1'b1;
            if (start_run) begin
              state  <= S_RUN;
              strb_q <= op_strobe(op_in);
              addr   <= ADDR_W'(base_in);
            end else begin
              state <= S_FIN;
              done  <= 1'b1;
              err   <= !op_legal(op_in);
            end
          end
        end
        S_RUN: begin
          if (last_beat) begin
            strb_q <= 4'b0000;
            addr   <= '0;
            if (op_q == OP_COMPUTE) begin
              state <= S_DRAIN;
            end else begin
              state <= S_FIN;
              done  <= 1'b1;
            end
          end else begin
            addr <= addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (last_beat) begin
            state <= S_FIN;
            done  <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Busy-cycle counter, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cycles <= 32'd0;
    end else if (busy) begin
      perf_busy_cycles <= sat_inc32(perf_busy_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_array_controller.sv
// Self-checking bench for array_controller: directed cases plus randomized
// instructions, compared cycle by cycle against an expected-trace model.
// Build with CTRL_PERF_CNT_EN defined to also check perf_busy_cycles.
module tb_array_controller;

  localparam int ARRAY_N = 4;
  localparam int ADDR_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [63:0]       instr_in;
  logic              instr_valid;
  logic              instr_ready;
  logic              wt_load_en;
  logic              act_load_en;
  logic              compute_en;
  logic              store_en;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              done;
  logic              err;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0]       perf_busy_cycles;
  int                perf_model;
`endif

  array_controller #(
    .ARRAY_N (ARRAY_N),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .wt_load_en  (wt_load_en),
    .act_load_en (act_load_en),
    .compute_en  (compute_en),
    .store_en    (store_en),
    .addr        (addr),
    .busy        (busy),
    .done        (done),
    .err         (err)
`ifdef CTRL_PERF_CNT_EN
    ,
    .perf_busy_cycles (perf_busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One expected output cycle: strobes {store, compute, act, wt}.
  typedef struct packed {
    logic [3:0]  strb;
    logic [15:0] addr;
    logic        busy;
    logic        done;
    logic        err;
  } beat_t;

  beat_t exp_q[$];

  function automatic logic [63:0] mk_instr(input logic [3:0] op, input logic [15:0] base,
                                           input logic [11:0] len);
    return {op, base, len, 32'($urandom)};
  endfunction

  // Expected trace from acceptance to the done cycle, derived from the
  // instruction semantics: LEN strobe beats, optional drain, one done cycle.
  task automatic build_trace(input logic [3:0] op, input logic [15:0] base, input int len);
    bit legal;
    legal = (op <= 4'd4);
    exp_q.delete();
    if (legal && op != 4'd0 && len != 0) begin
      for (int i = 0; i < len; i++)
        exp_q.push_back('{strb: 4'b0001 << (op - 4'd1), addr: 16'((int'(base) + i) % 65536),
                          busy: 1'b1, done: 1'b0, err: 1'b0});
      if (op == 4'd3)
        for (int i = 0; i < 2 * ARRAY_N - 1; i++)
          exp_q.push_back('{strb: 4'b0000, addr: 16'h0000, busy: 1'b1, done: 1'b0, err: 1'b0});
    end
    exp_q.push_back('{strb: 4'b0000, addr: 16'h0000, busy: 1'b1, done: 1'b1, err: !legal});
  endtask

  task automatic check_beat(input string tag, input beat_t e, input logic exp_ready);
    chk({tag, ".strb"},  {28'd0, store_en, compute_en, act_load_en, wt_load_en}, {28'd0, e.strb});
    chk({tag, ".addr"},  {16'd0, addr}, {16'd0, e.addr});
    chk({tag, ".busy"},  {31'd0, busy}, {31'd0, e.busy});
    chk({tag, ".done"},  {31'd0, done}, {31'd0, e.done});
    chk({tag, ".err"},   {31'd0, err},  {31'd0, e.err});
    chk({tag, ".ready"}, {31'd0, instr_ready}, {31'd0, exp_ready});
  endtask

  localparam beat_t IDLE_BEAT = '{strb: 4'b0000, addr: 16'h0000, busy: 1'b0, done: 1'b0, err: 1'b0};

  // Called at a negedge with the DUT idle; returns at the negedge after FIN.
  // While executing, instr_valid may stay high with junk that must be ignored.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [15:0] base,
                           input int len, input bit hold_valid);
    build_trace(op, base, len);
    check_beat({tag, ".idle"}, IDLE_BEAT, 1'b1);
    instr_in    = mk_instr(op, base, 12'(len));
    instr_valid = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge clk);
      instr_in    = {$urandom, $urandom};
      instr_valid = hold_valid;
      check_beat($sformatf("%s.c%0d", tag, i), exp_q[i], 1'b0);
`ifdef CTRL_PERF_CNT_EN
      perf_model++;
`endif
    end
    instr_valid = 1'b0;
    @(negedge clk);
`ifdef CTRL_PERF_CNT_EN
    chk({tag, ".perf"}, perf_busy_cycles, 32'(perf_model));
`endif
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] base;
    int          len;

    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_in    = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_beat("reset", IDLE_BEAT, 1'b1);
`ifdef CTRL_PERF_CNT_EN
    chk("reset.perf", perf_busy_cycles, 32'd0);
    perf_model = 0;
`endif
    rst = 1'b0;

    // Compute with drain; busy spans 2 + 7 + 1 cycles.
    run_instr("compute_len2", 4'd3, 16'h1234, 2, 1'b1);
`ifdef CTRL_PERF_CNT_EN
    chk("perf_after_compute", perf_busy_cycles, 32'd10);
`endif
    run_instr("load_w_len3", 4'd1, 16'h0100, 3, 1'b0);
    run_instr("illegal_op9", 4'd9, 16'h5555, 4, 1'b1);
    run_instr("store_wrap",  4'd4, 16'hFFFF, 2, 1'b0);
    run_instr("nop",         4'd0, 16'h0042, 3, 1'b1);
    run_instr("len_zero",    4'd2, 16'h0042, 0, 1'b0);

    // Reset during beat index 2 of a LOAD_A, LEN=5.
    build_trace(4'd2, 16'h0800, 5);
    check_beat("rst_mid.idle", IDLE_BEAT, 1'b1);
    instr_in    = mk_instr(4'd2, 16'h0800, 12'd5);
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      check_beat($sformatf("rst_mid.c%0d", i), exp_q[i], 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    check_beat("rst_mid.after", IDLE_BEAT, 1'b1);
`ifdef CTRL_PERF_CNT_EN
    chk("rst_mid.perf", perf_busy_cycles, 32'd0);
    perf_model = 0;
`endif
    rst = 1'b0;
    run_instr("nop_after_rst", 4'd0, 16'h0000, 1, 1'b0);

    // Randomized instruction stream, back-to-back at the earliest slot.
    for (int n = 0; n < 40; n++) begin
      op   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 4));
      len  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 9));
      base = 16'($urandom);
      if ($urandom_range(0, 5) == 0) base = 16'hFFFF - 16'($urandom_range(0, 3));
      run_instr($sformatf("rand%0d", n), op, base, len, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
